// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter that shares one W-bit adder between
// N requesters. A winning requester's operands are latched at grant, the
// W+1-bit sum is registered one cycle later with a one-cycle done pulse,
// and the grant is released on the following cycle.
module adder_share_arb #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   a_bus,
   input  logic [N*W-1:0]   b_bus,
   output logic [N-1:0]     gnt,
   output logic [N-1:0]     done,
   output logic [W:0]       sum,
   output logic             busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  ptr_q, ptr_d;
   logic [PW-1:0]  sel_q, sel_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [N-1:0]   done_q, done_d;
   logic [W:0]     sum_q, sum_d;
   logic [W-1:0]   a_lat_q, a_lat_d;
   logic [W-1:0]   b_lat_q, b_lat_d;

   logic [PW-1:0]  pick;
   logic           pick_valid;

   logic [W-1:0]   a_arr [N];
   logic [W-1:0]   b_arr [N];

   // unpack the flat operand buses into per-requester slices
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slice
         assign a_arr[gi] = a_bus[gi*W +: W];
         assign b_arr[gi] = b_bus[gi*W +: W];
      end
   endgenerate

   // round-robin search starting at ptr; walking the offsets downwards lets
   // the smallest offset (highest priority) overwrite any later candidate
   always_comb begin
      logic [PW-1:0] idx;
      pick       = '0;
      pick_valid = 1'b0;
      idx        = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr_q) + i) % N);
         if (req[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   // next-state and datapath updates for the IDLE -> EXEC -> DONE sequence
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      sum_d   = sum_q;
      a_lat_d = a_lat_q;
      b_lat_d = b_lat_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = EXEC;
               sel_d   = pick;
               gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
               a_lat_d = a_arr[pick];
               b_lat_d = b_arr[pick];
            end
         end
         EXEC: begin
            // widen both operands so the carry lands in the top sum bit
            sum_d   = {1'b0, a_lat_q} + {1'b0, b_lat_q};
            done_d  = gnt_q;
            state_d = DONE;
         end
         DONE: begin
            gnt_d   = '0;
            ptr_d   = (sel_q == PW'(N - 1)) ? '0 : sel_q + PW'(1);
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers; reset aborts any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         sum_q   <= '0;
         a_lat_q <= '0;
         b_lat_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         a_lat_q <= a_lat_d;
         b_lat_q <= b_lat_d;
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign busy = (state_q != IDLE);

   // immediate self-checks on grant/done encoding and the registered result
   always @(posedge clk) begin
      if (rst_n) begin
         assert ($onehot0(gnt_q))
            else $error("gnt is not one-hot or zero: %b", gnt_q);
         assert ((done_q & ~gnt_q) == '0)
            else $error("done %b not a subset of gnt %b", done_q, gnt_q);
         assert ($onehot0(done_q))
            else $error("done is not at most one-hot: %b", done_q);
         if (done_q != '0) begin
            assert (sum_q == ({1'b0, a_lat_q} + {1'b0, b_lat_q}))
               else $error("sum %0d does not match latched operands", sum_q);
         end
         assert (busy == (gnt_q != '0))
            else $error("busy %b inconsistent with gnt %b", busy, gnt_q);
      end
   end

endmodule
